// File: rtl/dot_bank.sv
// Per-frame dot consumption tracker: scans every dot against the latched Pac-Man
// position, keeps the eaten bitmap, score, remaining count and level-clear flag.
module dot_bank #(
   parameter int unsigned NUM_DOTS   = 64,
   parameter int unsigned IDX_W      = $clog2(NUM_DOTS),
   parameter int unsigned HIT_RADIUS = 6,
   parameter int unsigned DOT_PTS    = 10,
   parameter int unsigned POWER_PTS  = 50
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             frame_start,
   input  logic             new_level,
   input  logic [9:0]       pacX,
   input  logic [9:0]       pacY,
   output logic [IDX_W-1:0] dot_idx,
   input  logic [9:0]       dotX,
   input  logic [9:0]       dotY,
   input  logic             dotPower,
   input  logic [IDX_W-1:0] query_idx,
   output logic             query_eaten,
   output logic             busy,
   output logic             scan_done,
   output logic             eat_pulse,
   output logic             power_pulse,
   output logic [15:0]      score,
   output logic [IDX_W:0]   dots_left,
   output logic             level_clear
);

   localparam int unsigned COORD_W = 10;
   localparam int unsigned DIFF_W  = COORD_W + 1;
   localparam int unsigned SCORE_W = 16;
   localparam int unsigned CNT_W   = IDX_W + 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     idx;
   logic [COORD_W-1:0]   pac_x_l, pac_y_l;
   logic [NUM_DOTS-1:0]  eaten;

   logic                 last_idx;
   logic signed [DIFF_W-1:0] dx, dy;
   logic [DIFF_W-1:0]    adx, ady;
   logic                 hit, eat_c;
   logic [SCORE_W-1:0]   pts, score_nxt;
   logic [SCORE_W:0]     score_sum;

   assign last_idx = (idx == IDX_W'(NUM_DOTS - 1));

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state; new_level overrides everything and drops back to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_start) state_nxt = SCAN;
         SCAN:    if (last_idx)    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (new_level) state_nxt = IDLE;
   end

   // Signed 11-bit distance so coordinates near 0 or 1023 never wrap into a hit
   always_comb begin
      dx        = $signed({1'b0, dotX}) - $signed({1'b0, pac_x_l});
      dy        = $signed({1'b0, dotY}) - $signed({1'b0, pac_y_l});
      adx       = dx[DIFF_W-1] ? DIFF_W'(-dx) : DIFF_W'(dx);
      ady       = dy[DIFF_W-1] ? DIFF_W'(-dy) : DIFF_W'(dy);
      hit       = (adx <= DIFF_W'(HIT_RADIUS)) && (ady <= DIFF_W'(HIT_RADIUS));
      eat_c     = (state == SCAN) && hit && !eaten[idx] && !new_level;
      pts       = dotPower ? SCORE_W'(POWER_PTS) : SCORE_W'(DOT_PTS);
      score_sum = (SCORE_W + 1)'(score) + (SCORE_W + 1)'(pts);
      score_nxt = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
   end

   // Scan index, position latch, bitmap and scoring
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         idx         <= '0;
         pac_x_l     <= '0;
         pac_y_l     <= '0;
         eaten       <= '0;
         dots_left   <= CNT_W'(NUM_DOTS);
         score       <= '0;
         eat_pulse   <= 1'b0;
         power_pulse <= 1'b0;
      end else begin
         eat_pulse   <= eat_c;
         power_pulse <= eat_c && dotPower;
         if (new_level) begin
            idx       <= '0;
            eaten     <= '0;
            dots_left <= CNT_W'(NUM_DOTS);
         end else begin
            if (state == IDLE && frame_start) begin
               pac_x_l <= pacX;
               pac_y_l <= pacY;
               idx     <= '0;
            end else if (state == SCAN) begin
               idx <= last_idx ? '0 : idx + IDX_W'(1);
            end
            if (eat_c) begin
               eaten[idx] <= 1'b1;
               dots_left  <= dots_left - CNT_W'(1);
               score      <= score_nxt;
            end
         end
      end
   end

   assign dot_idx     = idx;
   assign query_eaten = eaten[query_idx];
   assign busy        = (state != IDLE);
   assign scan_done   = (state == DONE);
   assign level_clear = (dots_left == '0);

endmodule

// File: tb/tb_dot_bank.sv
// Directed bench for dot_bank with a 4-dot coordinate table driven from dot_idx.
module tb_dot_bank;

   localparam int unsigned N     = 4;
   localparam int unsigned IDX_W = 2;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             frame_start, new_level;
   logic [9:0]       pacX, pacY, dotX, dotY;
   logic             dotPower;
   logic [IDX_W-1:0] dot_idx, query_idx;
   logic             query_eaten, busy, scan_done, eat_pulse, power_pulse, level_clear;
   logic [15:0]      score;
   logic [IDX_W:0]   dots_left;

   logic [9:0] tx [N];
   logic [9:0] ty [N];
   logic       tp [N];

   int n_checks = 0;
   int n_errors = 0;

   dot_bank #(.NUM_DOTS(N)) dut (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .new_level(new_level),
      .pacX(pacX), .pacY(pacY), .dot_idx(dot_idx), .dotX(dotX), .dotY(dotY),
      .dotPower(dotPower), .query_idx(query_idx), .query_eaten(query_eaten),
      .busy(busy), .scan_done(scan_done), .eat_pulse(eat_pulse),
      .power_pulse(power_pulse), .score(score), .dots_left(dots_left),
      .level_clear(level_clear)
   );

   always #5 Clk = ~Clk;

   always_comb begin
      dotX     = tx[dot_idx];
      dotY     = ty[dot_idx];
      dotPower = tp[dot_idx];
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse_new_level();
      new_level = 1'b1;
      tick();
      new_level = 1'b0;
   endtask

   task automatic set_table(input int i, input int x, input int y, input logic p);
      tx[i] = 10'(x);
      ty[i] = 10'(y);
      tp[i] = p;
   endtask

   // One complete scan; returns observed activity counts
   task automatic run_scan(output int busy_n, output int eat_n, output int pow_n,
                           output int done_n, output int run_max, output int idx_bad,
                           output int first_eat);
      int run;
      busy_n = 0; eat_n = 0; pow_n = 0; done_n = 0; run_max = 0; idx_bad = 0;
      first_eat = -1; run = 0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int c = 0; c < int'(N) + 8; c++) begin
         if (c < int'(N) && dot_idx !== IDX_W'(c)) idx_bad++;
         if (busy) busy_n++;
         if (scan_done) done_n++;
         if (power_pulse) pow_n++;
         if (eat_pulse) begin
            eat_n++;
            run++;
            if (run > run_max) run_max = run;
            if (first_eat < 0) first_eat = c;
         end else begin
            run = 0;
         end
         if (!busy && !eat_pulse) break;
         tick();
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; frame_start = 1'b0; new_level = 1'b0;
      pacX = '0; pacY = '0; query_idx = '0;
      tick(); tick();
      Reset = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b0 || scan_done !== 1'b0 || eat_pulse !== 1'b0 || power_pulse !== 1'b0) begin
         n_errors++; $display("FAIL reset_flags: got busy=%b done=%b eat=%b pow=%b want 0000", busy, scan_done, eat_pulse, power_pulse); end
      n_checks++; if (score !== 16'd0 || dots_left !== 3'd4 || level_clear !== 1'b0) begin
         n_errors++; $display("FAIL reset_counts: got score=%0d left=%0d clear=%b want 0 4 0", score, dots_left, level_clear); end
      n_checks++; if (dot_idx !== 2'd0) begin
         n_errors++; $display("FAIL reset_idx: got %0d want 0", dot_idx); end
      for (int i = 0; i < int'(N); i++) begin
         query_idx = IDX_W'(i); #1;
         n_checks++; if (query_eaten !== 1'b0) begin
            n_errors++; $display("FAIL reset_bitmap[%0d]: got %b want 0", i, query_eaten); end
      end
   endtask

   task automatic test_basic_eat();
      int b, e, p, d, r, ib, fe;
      pacX = 10'd104; pacY = 10'd95;
      run_scan(b, e, p, d, r, ib, fe);
      n_checks++; if (b !== 5 || d !== 1) begin
         n_errors++; $display("FAIL basic_busy_done: got busy=%0d done=%0d want 5 1", b, d); end
      n_checks++; if (e !== 1 || p !== 0 || fe !== 1) begin
         n_errors++; $display("FAIL basic_eat: got eat=%0d pow=%0d first=%0d want 1 0 1", e, p, fe); end
      n_checks++; if (ib !== 0) begin
         n_errors++; $display("FAIL basic_idx_seq: got %0d bad indices want 0", ib); end
      n_checks++; if (score !== 16'd10 || dots_left !== 3'd3) begin
         n_errors++; $display("FAIL basic_score: got score=%0d left=%0d want 10 3", score, dots_left); end
      query_idx = 2'd0; #1;
      n_checks++; if (query_eaten !== 1'b1) begin
         n_errors++; $display("FAIL basic_query0: got %b want 1", query_eaten); end
      query_idx = 2'd1; #1;
      n_checks++; if (query_eaten !== 1'b0) begin
         n_errors++; $display("FAIL basic_query1: got %b want 0", query_eaten); end
   endtask

   task automatic test_no_reeat_and_radius();
      int b, e, p, d, r, ib, fe;
      run_scan(b, e, p, d, r, ib, fe);
      n_checks++; if (e !== 0 || score !== 16'd10 || dots_left !== 3'd3) begin
         n_errors++; $display("FAIL reeat: got eat=%0d score=%0d left=%0d want 0 10 3", e, score, dots_left); end
      pulse_new_level();
      pacX = 10'd106; pacY = 10'd100;
      run_scan(b, e, p, d, r, ib, fe);
      n_checks++; if (e !== 1 || score !== 16'd20) begin
         n_errors++; $display("FAIL radius_edge_hit: got eat=%0d score=%0d want 1 20", e, score); end
      pulse_new_level();
      pacX = 10'd107;
      run_scan(b, e, p, d, r, ib, fe);
      n_checks++; if (e !== 0 || score !== 16'd20 || dots_left !== 3'd4) begin
         n_errors++; $display("FAIL radius_miss: got eat=%0d score=%0d left=%0d want 0 20 4", e, score, dots_left); end
   endtask

   task automatic test_no_wrap();
      int b, e, p, d, r, ib, fe;
      set_table(1, 1020, 3, 1'b0);
      pacX = 10'd2; pacY = 10'd0;
      run_scan(b, e, p, d, r, ib, fe);
      n_checks++; if (e !== 0 || score !== 16'd20) begin
         n_errors++; $display("FAIL wrap_low: got eat=%0d score=%0d want 0 20", e, score); end
      pacX = 10'd1018;
      run_scan(b, e, p, d, r, ib, fe);
      n_checks++; if (e !== 1 || score !== 16'd30 || dots_left !== 3'd3) begin
         n_errors++; $display("FAIL wrap_high_hit: got eat=%0d score=%0d left=%0d want 1 30 3", e, score, dots_left); end
      // A dot at X=2 must not look 6 px away from a pac at X=1020
      pulse_new_level();
      set_table(0, 2, 3, 1'b0);
      pacX = 10'd1020; pacY = 10'd3;
      run_scan(b, e, p, d, r, ib, fe);
      query_idx = 2'd0; #1;
      n_checks++; if (e !== 1 || query_eaten !== 1'b0 || score !== 16'd40) begin
         n_errors++; $display("FAIL wrap_x_near_zero: got eat=%0d q0=%b score=%0d want 1 0 40", e, query_eaten, score); end
      set_table(0, 100, 100, 1'b0);
   endtask

   task automatic test_power();
      int b, e, p, d, r, ib, fe;
      pulse_new_level();
      tp[2] = 1'b1;
      pacX = 10'd300; pacY = 10'd100;
      run_scan(b, e, p, d, r, ib, fe);
      n_checks++; if (e !== 1 || p !== 1 || fe !== 3) begin
         n_errors++; $display("FAIL power_pulses: got eat=%0d pow=%0d first=%0d want 1 1 3", e, p, fe); end
      n_checks++; if (score !== 16'd90 || dots_left !== 3'd3) begin
         n_errors++; $display("FAIL power_score: got score=%0d left=%0d want 90 3", score, dots_left); end
      tp[2] = 1'b0;
   endtask

   task automatic test_level_clear_and_abort();
      int b, e, p, d, r, ib, fe, dn;
      for (int i = 0; i < int'(N); i++) set_table(i, 500, 500, 1'b0);
      pulse_new_level();
      pacX = 10'd500; pacY = 10'd500;
      run_scan(b, e, p, d, r, ib, fe);
      n_checks++; if (e !== 4 || r !== 4) begin
         n_errors++; $display("FAIL back_to_back: got eat=%0d run=%0d want 4 4", e, r); end
      n_checks++; if (score !== 16'd130 || dots_left !== 3'd0 || level_clear !== 1'b1) begin
         n_errors++; $display("FAIL level_clear: got score=%0d left=%0d clear=%b want 130 0 1", score, dots_left, level_clear); end
      run_scan(b, e, p, d, r, ib, fe);
      n_checks++; if (e !== 0 || b !== 5 || d !== 1 || score !== 16'd130) begin
         n_errors++; $display("FAIL cleared_rescan: got eat=%0d busy=%0d done=%0d score=%0d want 0 5 1 130", e, b, d, score); end
      // Abort a scan of the cleared board
      frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
      pulse_new_level();
      n_checks++; if (busy !== 1'b0 || dots_left !== 3'd4 || level_clear !== 1'b0) begin
         n_errors++; $display("FAIL abort_state: got busy=%b left=%0d clear=%b want 0 4 0", busy, dots_left, level_clear); end
      for (int i = 0; i < int'(N); i++) begin
         query_idx = IDX_W'(i); #1;
         n_checks++; if (query_eaten !== 1'b0) begin
            n_errors++; $display("FAIL abort_bitmap[%0d]: got %b want 0", i, query_eaten); end
      end
      dn = 0;
      for (int c = 0; c < 8; c++) begin if (scan_done) dn++; tick(); end
      n_checks++; if (dn !== 0 || score !== 16'd130) begin
         n_errors++; $display("FAIL abort_no_done: got done=%0d score=%0d want 0 130", dn, score); end
      // new_level on the very cycle dot 0 would be eaten
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      pulse_new_level();
      query_idx = 2'd0; #1;
      n_checks++; if (eat_pulse !== 1'b0 || score !== 16'd130 || dots_left !== 3'd4 || query_eaten !== 1'b0) begin
         n_errors++; $display("FAIL abort_suppress: got eat=%b score=%0d left=%0d q0=%b want 0 130 4 0", eat_pulse, score, dots_left, query_eaten); end
   endtask

   task automatic test_frame_while_busy();
      int b, d, e, idle_busy;
      b = 0; d = 0; e = 0; idle_busy = 0;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         frame_start = (c == 2 || c == 4);
         if (busy) b++;
         if (scan_done) d++;
         if (eat_pulse) e++;
         if (!busy && !eat_pulse && c > 0) break;
         tick();
      end
      frame_start = 1'b0;
      for (int c = 0; c < 4; c++) begin if (busy) idle_busy++; tick(); end
      n_checks++; if (b !== 5 || d !== 1 || idle_busy !== 0) begin
         n_errors++; $display("FAIL busy_ignore: got busy=%0d done=%0d later_busy=%0d want 5 1 0", b, d, idle_busy); end
      n_checks++; if (e !== 4 || score !== 16'd170) begin
         n_errors++; $display("FAIL busy_eats: got eat=%0d score=%0d want 4 170", e, score); end
   endtask

   task automatic test_reset_midscan();
      int late_busy;
      pulse_new_level();
      frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
      #2 Reset = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0 || eat_pulse !== 1'b0 || scan_done !== 1'b0 || power_pulse !== 1'b0 || dot_idx !== 2'd0) begin
         n_errors++; $display("FAIL async_reset_ctl: got busy=%b eat=%b done=%b pow=%b idx=%0d want 0 0 0 0 0", busy, eat_pulse, scan_done, power_pulse, dot_idx); end
      n_checks++; if (score !== 16'd0 || dots_left !== 3'd4 || level_clear !== 1'b0) begin
         n_errors++; $display("FAIL async_reset_cnt: got score=%0d left=%0d clear=%b want 0 4 0", score, dots_left, level_clear); end
      #2 Reset = 1'b0;
      late_busy = 0;
      for (int c = 0; c < 4; c++) begin tick(); if (busy) late_busy++; end
      n_checks++; if (late_busy !== 0 || score !== 16'd0) begin
         n_errors++; $display("FAIL reset_no_resume: got busy_cycles=%0d score=%0d want 0 0", late_busy, score); end
   endtask

   task automatic test_saturation();
      int b, e, p, d, r, ib, fe, model;
      for (int i = 0; i < int'(N); i++) set_table(i, 500, 500, 1'b1);
      model = 0;
      for (int lvl = 0; lvl < 329; lvl++) begin
         run_scan(b, e, p, d, r, ib, fe);
         for (int k = 0; k < int'(N); k++) model = (model + 50 > 65535) ? 65535 : model + 50;
         n_checks++; if (score !== 16'(model)) begin
            n_errors++; $display("FAIL saturate_lvl%0d: got score=%0d want %0d", lvl, score, model); end
         pulse_new_level();
      end
      n_checks++; if (score !== 16'hFFFF) begin
         n_errors++; $display("FAIL saturate_final: got %h want ffff", score); end
   endtask

   initial begin
      for (int i = 0; i < int'(N); i++) set_table(i, 0, 0, 1'b0);
      set_table(0, 100, 100, 1'b0);
      set_table(1, 200, 100, 1'b0);
      set_table(2, 300, 100, 1'b0);
      set_table(3, 100, 5, 1'b0);
      test_reset();
      test_basic_eat();
      test_no_reeat_and_radius();
      test_no_wrap();
      test_power();
      test_level_clear_and_abort();
      test_frame_while_busy();
      test_reset_midscan();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
